// File: rtl/xctcmsg_send_arbiter_if.sv
// Message type and the arbiter's bus bundle: per-requester valid/ready/data
// on one side, the registered send channel toward the NoC on the other.

package xctcmsg_pkg;

    typedef struct packed {
        logic [7:0]  dest;
        logic [3:0]  tag;
        logic [19:0] payload;
    } interface_send_data_t;

endpackage

interface xctcmsg_send_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    import xctcmsg_pkg::*;

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    // Requester side
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    interface_send_data_t req_data_i [NUM_REQ];

    // Send channel side
    logic                 out_valid_o;
    logic                 out_ready_i;
    interface_send_data_t out_data_o;
    logic [PTR_W-1:0]     out_src_o;
    logic                 busy_o;

    // Arbiter view
    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  out_ready_i,
        output req_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_src_o,
        output busy_o
    );

    // Environment view (requesters plus downstream consumer)
    modport master (
        output req_valid_i,
        output req_data_i,
        output out_ready_i,
        input  req_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_src_o,
        input  busy_o
    );

endinterface

// File: rtl/xctcmsg_send_arbiter.sv
// Round-robin arbiter sharing the xctcmsg send channel between NUM_REQ
// requesters, followed by a single registered output stage.

module xctcmsg_send_arbiter
    import xctcmsg_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    xctcmsg_send_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CW    = PTR_W + 1;
    localparam logic [CW-1:0] NUM_REQ_C = CW'(NUM_REQ);

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant;
    logic [PTR_W-1:0]     ptr_after_grant;
    logic                 gnt_vld;
    logic                 load;
    logic [CW-1:0]        cand;
    logic [CW-1:0]        ptr_inc;
    logic                 found;

    logic                 out_valid;
    interface_send_data_t out_data;
    logic [PTR_W-1:0]     out_src;

    // Output register may take a new message when empty or being drained.
    assign load    = !out_valid || bus.out_ready_i;
    assign gnt_vld = |bus.req_valid_i;

    // Search requesters starting at rr_ptr; wrap by compare-and-subtract so
    // non-power-of-two NUM_REQ works.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!found && bus.req_valid_i[cand[PTR_W-1:0]]) begin
                grant = cand[PTR_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Pointer moves to the requester just after the winner.
    always_comb begin
        ptr_inc = {1'b0, grant} + CW'(1);
        if (ptr_inc >= NUM_REQ_C) begin
            ptr_inc = ptr_inc - NUM_REQ_C;
        end
        ptr_after_grant = ptr_inc[PTR_W-1:0];
    end

    // One-hot accept toward the winning requester, only when the output
    // register can take its message this cycle.
    always_comb begin
        bus.req_ready_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready_o[i] = load && gnt_vld && (grant == PTR_W'(i));
        end
    end

    // Output stage and round-robin pointer; everything holds while stalled.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (gnt_vld) begin
                out_valid <= 1'b1;
                out_data  <= bus.req_data_i[grant];
                out_src   <= grant;
                rr_ptr    <= ptr_after_grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign bus.out_src_o   = out_src;
    assign bus.busy_o      = out_valid || gnt_vld;

endmodule

// File: tb/tb_xctcmsg_send_arbiter.sv
// Bench for xctcmsg_send_arbiter: one instance with two requesters and one
// with three, driven in lockstep and compared every cycle against a
// behavioural model, plus directed scenario checks.

module tb_xctcmsg_send_arbiter;
    import xctcmsg_pkg::*;

    logic clk;
    logic rstn;

    int total = 0;
    int bad   = 0;

    xctcmsg_send_arbiter_if #(.NUM_REQ(2)) if2 ();
    xctcmsg_send_arbiter_if #(.NUM_REQ(3)) if3 ();

    xctcmsg_send_arbiter #(.NUM_REQ(2)) u2 (.clk_i(clk), .rstn_i(rstn), .bus(if2));
    xctcmsg_send_arbiter #(.NUM_REQ(3)) u3 (.clk_i(clk), .rstn_i(rstn), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per instance: index 0 is NUM_REQ=2, index 1 is NUM_REQ=3
    bit          mv [2];
    logic [31:0] md [2];
    int          ms [2];
    int          mp [2];
    bit          nv [2];
    logic [31:0] nd [2];
    int          ns [2];
    int          np [2];
    logic [2:0]  acc [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic interface_send_data_t mk(input logic [3:0] t, input logic [19:0] p);
        mk = '{dest: 8'h00, tag: t, payload: p};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; md[d] = '0; ms[d] = 0; mp[d] = 0; acc[d] = '0;
        end
    endtask

    // Compare one instance against the model, then prepare the model's
    // post-edge state from the rules: scan from the pointer, modulo n.
    task automatic model_check(input int d, input int n, input logic [2:0] vld,
                               input logic ordy, input logic [31:0] din0,
                               input logic [31:0] din1, input logic [31:0] din2,
                               input logic ov, input logic [31:0] od,
                               input logic [1:0] os, input logic [2:0] rdy,
                               input logic bsy);
        logic [31:0] din [3];
        int          gi;
        bit          ld;
        logic [2:0]  exp_rdy;
        string       pfx;
        pfx = (d == 0) ? "u2_" : "u3_";
        din[0] = din0; din[1] = din1; din[2] = din2;
        ld = !mv[d] || (ordy === 1'b1);
        gi = -1;
        for (int k = 0; k < n; k++) begin
            int i;
            i = (mp[d] + k) % n;
            if (gi < 0 && vld[i]) gi = i;
        end
        exp_rdy = (ld && gi >= 0) ? 3'(1 << gi) : 3'b000;
        chk({pfx, "ready"}, 32'(rdy), 32'(exp_rdy));
        chk({pfx, "valid"}, 32'(ov), 32'(mv[d]));
        chk({pfx, "data"},  od, md[d]);
        chk({pfx, "src"},   32'(os), 32'(ms[d]));
        chk({pfx, "busy"},  32'(bsy), 32'(mv[d] || (vld != 3'b000)));
        nv[d] = mv[d]; nd[d] = md[d]; ns[d] = ms[d]; np[d] = mp[d];
        if (ld) begin
            if (gi >= 0) begin
                nv[d] = 1'b1; nd[d] = din[gi]; ns[d] = gi; np[d] = (gi + 1) % n;
            end else begin
                nv[d] = 1'b0;
            end
        end
        acc[d] = exp_rdy;
    endtask

    task automatic step();
        @(negedge clk);
        model_check(0, 2, {1'b0, if2.req_valid_i}, if2.out_ready_i,
                    if2.req_data_i[0], if2.req_data_i[1], 32'h0,
                    if2.out_valid_o, if2.out_data_o, {1'b0, if2.out_src_o},
                    {1'b0, if2.req_ready_o}, if2.busy_o);
        model_check(1, 3, if3.req_valid_i, if3.out_ready_i,
                    if3.req_data_i[0], if3.req_data_i[1], if3.req_data_i[2],
                    if3.out_valid_o, if3.out_data_o, if3.out_src_o,
                    if3.req_ready_o, if3.busy_o);
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                mv[d] = nv[d]; md[d] = nd[d]; ms[d] = ns[d]; mp[d] = np[d];
            end
        end
        #1;
    endtask

    initial begin
        int cnt [3];

        rstn = 1'b0;
        if2.req_valid_i = '0; if2.out_ready_i = 1'b1;
        if3.req_valid_i = '0; if3.out_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) if2.req_data_i[i] = '0;
        for (int i = 0; i < 3; i++) if3.req_data_i[i] = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        step();
        step();
        chk("rst_valid2", 32'(if2.out_valid_o), 32'd0);
        chk("rst_src2",   32'(if2.out_src_o), 32'd0);
        chk("rst_data2",  if2.out_data_o, 32'd0);
        chk("rst_busy2",  32'(if2.busy_o), 32'd0);
        chk("rst_valid3", 32'(if3.out_valid_o), 32'd0);
        rstn = 1'b1;

        // Single requester, NUM_REQ=2
        if2.req_valid_i = 2'b01;
        if2.req_data_i[0] = mk(4'h5, 20'h11111);
        #1;
        chk("single_ready", 32'(if2.req_ready_o), 32'h1);
        step();
        chk("single_valid", 32'(if2.out_valid_o), 32'd1);
        chk("single_tag",   32'(if2.out_data_o.tag), 32'h5);
        chk("single_src",   32'(if2.out_src_o), 32'd0);

        // Pointer is now 1: requester 1 wins with both valid
        if2.req_valid_i = 2'b11;
        if2.req_data_i[1] = mk(4'h6, 20'h22222);
        #1;
        chk("ptr1_ready", 32'(if2.req_ready_o), 32'h2);
        step();
        chk("ptr1_src", 32'(if2.out_src_o), 32'd1);
        chk("ptr1_tag", 32'(if2.out_data_o.tag), 32'h6);

        // Drain to empty
        if2.req_valid_i = 2'b00;
        step();
        chk("drain_valid", 32'(if2.out_valid_o), 32'd0);
        chk("drain_busy",  32'(if2.busy_o), 32'd0);

        // Backpressure: hold A, stall four cycles, then B loads on release
        if2.req_valid_i = 2'b01;
        if2.req_data_i[0] = mk(4'hA, 20'hAAAAA);
        step();
        chk("bp_load_tag", 32'(if2.out_data_o.tag), 32'hA);
        if2.out_ready_i = 1'b0;
        if2.req_valid_i = 2'b11;
        if2.req_data_i[0] = mk(4'hC, 20'hCCCCC);
        if2.req_data_i[1] = mk(4'hB, 20'hBBBBB);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_ready", 32'(if2.req_ready_o), 32'h0);
            step();
            chk("bp_hold_tag", 32'(if2.out_data_o.tag), 32'hA);
            chk("bp_hold_valid", 32'(if2.out_valid_o), 32'd1);
        end
        if2.out_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(if2.req_ready_o), 32'h2);
        step();
        chk("bp_next_tag", 32'(if2.out_data_o.tag), 32'hB);
        chk("bp_next_src", 32'(if2.out_src_o), 32'd1);
        if2.req_valid_i = 2'b00;
        step();

        // Full contention, NUM_REQ=3
        if3.req_valid_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            if3.req_data_i[i] = mk(4'(i + 1), 20'(i * 16));
            cnt[i] = 0;
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            for (int i = 0; i < 3; i++) cnt[i] += int'(if3.req_ready_o[i]);
            step();
            chk("cont_src",   32'(if3.out_src_o), 32'(c % 3));
            chk("cont_valid", 32'(if3.out_valid_o), 32'd1);
        end
        for (int i = 0; i < 3; i++) chk("cont_pulses", 32'(cnt[i]), 32'd2);

        // Pointer skip and wrap, NUM_REQ=3
        if3.req_valid_i = 3'b010;
        step();
        chk("skip_setup_src", 32'(if3.out_src_o), 32'd1);
        #1;
        chk("skip_ready", 32'(if3.req_ready_o), 32'h2);
        step();
        chk("skip_src", 32'(if3.out_src_o), 32'd1);
        if3.req_valid_i = 3'b001;
        #1;
        chk("wrap_ready", 32'(if3.req_ready_o), 32'h1);
        step();
        chk("wrap_src", 32'(if3.out_src_o), 32'd0);
        if3.req_valid_i = 3'b101;
        #1;
        chk("ptr1_n3_ready", 32'(if3.req_ready_o), 32'h4);
        step();
        chk("ptr1_n3_src", 32'(if3.out_src_o), 32'd2);
        if3.req_valid_i = 3'b000;
        step();

        // Reset mid-stall, NUM_REQ=2
        if2.req_valid_i = 2'b01;
        if2.req_data_i[0] = mk(4'h7, 20'h77777);
        step();
        if2.req_valid_i = 2'b00;
        if2.out_ready_i = 1'b0;
        step();
        chk("stall_valid", 32'(if2.out_valid_o), 32'd1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("rst_stall_valid", 32'(if2.out_valid_o), 32'd0);
        chk("rst_stall_src",   32'(if2.out_src_o), 32'd0);
        chk("rst_stall_data",  if2.out_data_o, 32'd0);
        if2.req_valid_i = 2'b11;
        if2.out_ready_i = 1'b1;
        #1;
        chk("post_rst_ready", 32'(if2.req_ready_o), 32'h1);
        step();
        chk("post_rst_src", 32'(if2.out_src_o), 32'd0);

        // Randomized traffic: requesters hold data until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!if2.req_valid_i[i] || acc[0][i]) begin
                    if2.req_valid_i[i] = ($urandom_range(0, 2) != 0);
                    if2.req_data_i[i]  = interface_send_data_t'($urandom);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!if3.req_valid_i[i] || acc[1][i]) begin
                    if3.req_valid_i[i] = ($urandom_range(0, 2) != 0);
                    if3.req_data_i[i]  = interface_send_data_t'($urandom);
                end
            end
            if2.out_ready_i = ($urandom_range(0, 3) != 0);
            if3.out_ready_i = ($urandom_range(0, 3) != 0);
            rstn = (c != 200);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
